uart_rx: RTL and testbench

- Serial UART receiver, 8N1, LSB first, idle-high line. It is the receive-side counterpart of the team's UART transmitter.
- Oversamples the asynchronous input line, validates the start and stop bits, and presents each byte through a valid/ack holding register. Consumers are a host-side echo/loopback and LED status logic.
- Flags framing errors and overruns.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync.sv | 31 +++
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants,
// common to the receiver and transmitter.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Metastability synchroniser for an asynchronous input; flops reset to the
// UART idle level so a reset never looks like a falling start edge.
module uart_sync
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{UART_IDLE_LEVEL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start/data/stop detection with a
// valid/ack holding register, framing-error pulse and sticky overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  // Start sample lands when the incremented count reaches HALF, so that
  // data bit i is sampled HALF + (i+1)*CLKS_PER_BIT cycles after T0.
  localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  logic rxs;

  uart_state_e                state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
  logic [UART_DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic                       rx_valid_q, rx_valid_d;
  logic                       frame_err_q, frame_err_d;
  logic                       overrun_q, overrun_d;
  logic                       load;

  uart_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .async_i(UART_RX),
    .sync_o (rxs)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    load        = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF_M1) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = IDLE;
          end else begin
            bit_idx_d = '0;
            state_d   = DATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rxs;
          if (bit_idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            load    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Holding register: a new byte always wins over a same-cycle ack.
  always_comb begin
    rx_data_d  = load ? shift_q : rx_data_q;
    rx_valid_d = load ? 1'b1 : (rx_ack ? 1'b0 : rx_valid_q);
    overrun_d  = overrun_q | (load & rx_valid_q & ~rx_ack);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit-serially, expected
// bytes queued at send time and popped when rx_valid is observed.
module tb_uart_rx;

  localparam int CPB     = 16;
  localparam int SYNC    = 2;
  localparam int HALF    = CPB / 2 - 1;
  localparam int LAT     = HALF + 9 * CPB + 1 + SYNC;
  localparam int WAIT_MAX = 12 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       UART_RX;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int fe_cnt      = 0;
  logic [7:0] sb[$];

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .UART_RX  (UART_RX),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
    UART_RX = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      repeat (CPB) tick();
    end
    UART_RX = stop_lvl;
    repeat (CPB) tick();
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (rx_valid !== 1'b1 && n < WAIT_MAX) begin
      tick();
      n++;
    end
    ok = (rx_valid === 1'b1);
  endtask

  function automatic logic [7:0] sb_pop();
    if (sb.size() == 0) return 8'hxx;
    return sb.pop_front();
  endfunction

  task automatic test_reset();
    reset = 1'b1; UART_RX = 1'b1; rx_ack = 1'b0;
    repeat (3) tick();
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_ovr: got %b expected 0", overrun); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    repeat (CPB) tick();
  endtask

  task automatic test_single();
    int n;
    int fe0;
    logic [7:0] exp;
    fe0 = fe_cnt;
    n = 0;
    sb.push_back(8'h48);
    fork
      send_byte(8'h48, 1'b1);
      begin
        while (rx_valid !== 1'b1 && n < WAIT_MAX) begin
          tick();
          n++;
        end
      end
    join
    exp = sb_pop();
    vectors++; if (n != LAT) begin miscompares++; $display("FAIL single_latency: got %0d expected %0d", n, LAT); end
    vectors++; if (rx_valid !== 1'b1 || rx_data !== exp) begin miscompares++; $display("FAIL single_data: got %h/%b expected %h/1", rx_data, rx_valid, exp); end
    vectors++; if (fe_cnt != fe0 || overrun !== 1'b0) begin miscompares++; $display("FAIL single_flags: got fe=%0d ovr=%b expected fe=0 ovr=0", fe_cnt - fe0, overrun); end
    rx_ack = 1'b1; tick(); rx_ack = 1'b0;
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL single_ack: got %b expected 0", rx_valid); end
    repeat (CPB) tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg[5];
    logic [7:0] exp;
    bit ok;
    int fe0;
    msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    fe0 = fe_cnt;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(msg[i]);
      send_byte(msg[i], 1'b1);
      wait_valid(ok);
      exp = sb_pop();
      vectors++; if (!ok || rx_data !== exp) begin miscompares++; $display("FAIL hello_byte%0d: got %h/%b expected %h/1", i, rx_data, rx_valid, exp); end
      rx_ack = 1'b1; tick(); rx_ack = 1'b0;
      vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL hello_ack%0d: got %b expected 0", i, rx_valid); end
    end
    vectors++; if (fe_cnt != fe0 || overrun !== 1'b0) begin miscompares++; $display("FAIL hello_flags: got fe=%0d ovr=%b expected fe=0 ovr=0", fe_cnt - fe0, overrun); end
  endtask

  task automatic test_frame_err();
    int fe0;
    bit ok;
    logic [7:0] exp;
    fe0 = fe_cnt;
    send_byte(8'h55, 1'b0);
    repeat (40 * CPB) tick();
    vectors++; if (fe_cnt - fe0 != 1) begin miscompares++; $display("FAIL ferr_pulses: got %0d expected 1", fe_cnt - fe0); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ferr_break_busy: got %b expected 1", busy); end
    vectors++; if (rx_data !== 8'h6F || rx_valid !== 1'b0) begin miscompares++; $display("FAIL ferr_hold: got %h/%b expected 6f/0", rx_data, rx_valid); end
    UART_RX = 1'b1;
    repeat (CPB) tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ferr_release: got busy=%b expected 0", busy); end
    sb.push_back(8'h21);
    send_byte(8'h21, 1'b1);
    wait_valid(ok);
    exp = sb_pop();
    vectors++; if (!ok || rx_data !== exp) begin miscompares++; $display("FAIL ferr_next: got %h/%b expected %h/1", rx_data, rx_valid, exp); end
    vectors++; if (fe_cnt - fe0 != 1) begin miscompares++; $display("FAIL ferr_next_pulses: got %0d expected 1", fe_cnt - fe0); end
    rx_ack = 1'b1; tick(); rx_ack = 1'b0;
    repeat (CPB) tick();
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt;
    UART_RX = 1'b0;
    repeat (5) tick();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL glitch_start: got busy=%b expected 1", busy); end
    UART_RX = 1'b1;
    repeat (2 * CPB) tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_busy: got %b expected 0", busy); end
    vectors++; if (rx_valid !== 1'b0 || fe_cnt != fe0) begin miscompares++; $display("FAIL glitch_out: got valid=%b fe=%0d expected 0/0", rx_valid, fe_cnt - fe0); end
  endtask

  task automatic test_overrun();
    bit ok;
    logic [7:0] exp;
    sb.push_back(8'h0A);
    send_byte(8'h0A, 1'b1);
    wait_valid(ok);
    exp = sb_pop();
    vectors++; if (!ok || rx_data !== exp || overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_first: got %h/%b ovr=%b expected %h/1 ovr=0", rx_data, rx_valid, overrun, exp); end
    sb.push_back(8'h0D);
    send_byte(8'h0D, 1'b1);
    exp = sb_pop();
    vectors++; if (rx_data !== exp || rx_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_second: got %h/%b expected %h/1", rx_data, rx_valid, exp); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    sb.push_back(8'h30);
    fork
      send_byte(8'h30, 1'b1);
      begin
        repeat (LAT - 1) tick();
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
      end
    join
    exp = sb_pop();
    vectors++; if (rx_data !== exp || rx_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_ack_load: got %h/%b expected %h/1", rx_data, rx_valid, exp); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    rx_ack = 1'b1; tick(); rx_ack = 1'b0;
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_ack: got %b expected 0", rx_valid); end
    repeat (CPB) tick();
  endtask

  task automatic test_reset_mid();
    int fe0;
    bit ok;
    logic [7:0] exp;
    fe0 = fe_cnt;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        repeat (5 * CPB + CPB / 2) tick();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rmid_busy_pre: got %b expected 1", busy); end
        reset = 1'b1;
        tick();
        vectors++; if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_data: got %h/%b expected 00/0", rx_data, rx_valid); end
        vectors++; if (frame_err !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rmid_flags: got fe=%b ovr=%b busy=%b expected 0/0/0", frame_err, overrun, busy); end
      end
    join
    reset = 1'b0;
    repeat (CPB) tick();
    vectors++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_idle: got busy=%b valid=%b expected 0/0", busy, rx_valid); end
    sb.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    wait_valid(ok);
    exp = sb_pop();
    vectors++; if (!ok || rx_data !== exp) begin miscompares++; $display("FAIL rmid_next: got %h/%b expected %h/1", rx_data, rx_valid, exp); end
    vectors++; if (fe_cnt != fe0 || overrun !== 1'b0) begin miscompares++; $display("FAIL rmid_next_flags: got fe=%0d ovr=%b expected 0/0", fe_cnt - fe0, overrun); end
    rx_ack = 1'b1; tick(); rx_ack = 1'b0;
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL sb_empty: got %0d left expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
